// File: rtl/deparser_layer_param_if.sv
`default_nettype none
// ============================================================================
// Module   : deparser_layer_param_if
// Desc     : Rule-table configuration bus for one deparser layer stage.
// Revision : 1.0 - initial release
// ============================================================================
interface deparser_layer_param_if;
   logic        i_rule_wren;
   logic        i_rule_rden;
   logic [31:0] i_rule_addr;
   logic [31:0] i_rule_wdata;
   logic        o_rule_rdata_valid;
   logic [31:0] o_rule_rdata;

   modport master (
      output i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata,
      input  o_rule_rdata_valid, o_rule_rdata
   );

   modport slave (
      input  i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata,
      output o_rule_rdata_valid, o_rule_rdata
   );
endinterface
`default_nettype wire

// File: rtl/deparser_layer_param.sv
`default_nettype none
// ============================================================================
// Module   : deparser_layer_param
// Desc     : Parameterised deparser layer: metadata write-back, header rotate,
//            metadata shift and masked type-byte rule lookup (2-cycle pipe).
// Options  : DEPARSER_LAYER_STATS_EN adds saturating hit/miss counters (sel6).
// Revision : 1.0 - initial release
// ============================================================================
module deparser_layer_param #(
   parameter int HEAD_W   = 1024,
   parameter int META_W   = 512,
   parameter int KEY_NUM  = 8,
   parameter int TYPE_NUM = 2,
   parameter int RULE_NUM = 4,
   parameter int LAYER_ID = 1
) (
   input  wire logic                  i_clk,
   input  wire logic                  i_rst_n,
   deparser_layer_param_if.slave      cfg,
   input  wire logic                  i_valid,
   input  wire logic [HEAD_W-1:0]     i_head,
   input  wire logic [META_W-1:0]     i_meta,
   input  wire logic [7:0]            i_head_ptr,
   input  wire logic [TYPE_NUM*8-1:0] i_type_offset,
   input  wire logic [KEY_NUM*8-1:0]  i_key_offset,
   input  wire logic [KEY_NUM*8-1:0]  i_key_replace,
   input  wire logic [KEY_NUM-1:0]    i_key_v,
   input  wire logic [7:0]            i_head_shift,
   input  wire logic [7:0]            i_meta_shift,
   output logic                       o_valid,
   output logic [HEAD_W-1:0]          o_head,
   output logic [META_W-1:0]          o_meta,
   output logic [7:0]                 o_head_ptr,
   output logic [TYPE_NUM*8-1:0]      o_type_offset,
   output logic [KEY_NUM*8-1:0]       o_key_offset,
   output logic [KEY_NUM*8-1:0]       o_key_replace,
   output logic [KEY_NUM-1:0]         o_key_v,
   output logic [7:0]                 o_head_shift,
   output logic [7:0]                 o_meta_shift,
   output logic                       o_hit,
   output logic [3:0]                 o_rule_id
);
   localparam int c_HW = HEAD_W / 16;
   localparam int c_MW = META_W / 16;
   localparam int c_HB = HEAD_W / 8;

   logic [7:0] r_data       [RULE_NUM][TYPE_NUM];
   logic [7:0] r_mask       [RULE_NUM][TYPE_NUM];
   logic [7:0] r_type_off   [RULE_NUM][TYPE_NUM];
   logic [7:0] r_key_off    [RULE_NUM][KEY_NUM];
   logic [7:0] r_key_rep    [RULE_NUM][KEY_NUM];
   logic       r_key_v      [RULE_NUM][KEY_NUM];
   logic [7:0] r_head_shift [RULE_NUM];
   logic [7:0] r_meta_shift [RULE_NUM];
   logic [RULE_NUM-1:0] r_valid;

   logic        w_layer_ok;
   logic [2:0]  w_sel;
   logic [3:0]  w_r;
   logic [3:0]  w_idx;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_layer_ok = (cfg.i_rule_addr[15:12] == 4'(LAYER_ID));
   assign w_sel      = cfg.i_rule_addr[10:8];
   assign w_idx      = cfg.i_rule_addr[7:4];
   assign w_r        = cfg.i_rule_addr[3:0];
   assign w_unused   = ^{cfg.i_rule_addr[31:16], cfg.i_rule_addr[11], cfg.i_rule_wdata[31:17]};

   // ---------------- stage 1: key write-back and type extraction ----------
   logic [15:0]          w_key_word [KEY_NUM];
   logic [KEY_NUM-1:0]   w_key_ok;
   logic [HEAD_W-1:0]    w_rep_head;
   logic [TYPE_NUM*8-1:0] w_type;

   always_comb begin
      w_rep_head = i_head;
      w_type     = '0;
      for (int k = 0; k < KEY_NUM; k++) begin
         w_key_word[k] = '0;
         w_key_ok[k]   = i_key_v[k] && (int'(i_key_offset[8*k +: 8]) < c_HW)
                                    && (int'(i_key_replace[8*k +: 8]) < c_MW);
         for (int m = 0; m < c_MW; m++)
            if (int'(i_key_replace[8*k +: 8]) == m)
               w_key_word[k] = i_meta[META_W-1-16*m -: 16];
      end
      // Ascending key order lets the highest key win on a shared target word.
      for (int w = 0; w < c_HW; w++)
         for (int k = 0; k < KEY_NUM; k++)
            if (w_key_ok[k] && int'(i_key_offset[8*k +: 8]) == w)
               w_rep_head[HEAD_W-1-16*w -: 16] = w_key_word[k];
      for (int j = 0; j < TYPE_NUM; j++)
         for (int b = 0; b < c_HB; b++)
            if (int'(i_type_offset[8*j +: 8]) == b)
               w_type[8*j +: 8] = w_rep_head[HEAD_W-1-8*b -: 8];
   end

   logic                  r1_valid;
   logic [HEAD_W-1:0]     r1_head;
   logic [META_W-1:0]     r1_meta;
   logic [7:0]            r1_head_ptr;
   logic [7:0]            r1_head_shift;
   logic [7:0]            r1_meta_shift;
   logic [TYPE_NUM*8-1:0] r1_type;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r1_valid      <= 1'b0;
         r1_head       <= '0;
         r1_meta       <= '0;
         r1_head_ptr   <= '0;
         r1_head_shift <= '0;
         r1_meta_shift <= '0;
         r1_type       <= '0;
      end else begin
         r1_valid <= i_valid;
         if (i_valid) begin
            r1_head       <= w_rep_head;
            r1_meta       <= i_meta;
            r1_head_ptr   <= i_head_ptr;
            r1_head_shift <= i_head_shift;
            r1_meta_shift <= i_meta_shift;
            r1_type       <= w_type;
         end
      end
   end

   // ---------------- stage 2: shifts and rule lookup ----------------------
   logic [31:0]           w_rot_words;
   logic [HEAD_W-1:0]     w_rot_head;
   logic [META_W-1:0]     w_shift_meta;
   logic [7:0]            w_ptr;
   logic [RULE_NUM-1:0]   w_rule_hit;
   logic                  w_hit;
   logic [3:0]            w_hit_id;
   logic [TYPE_NUM*8-1:0] w_nxt_type;
   logic [KEY_NUM*8-1:0]  w_nxt_koff;
   logic [KEY_NUM*8-1:0]  w_nxt_krep;
   logic [KEY_NUM-1:0]    w_nxt_kv;
   logic [7:0]            w_nxt_hs;
   logic [7:0]            w_nxt_ms;

   always_comb begin
      w_rot_words  = 32'(int'(r1_head_shift) % c_HW);
      w_rot_head   = (r1_head << (w_rot_words * 16)) | (r1_head >> (HEAD_W - w_rot_words * 16));
      w_ptr        = 8'((int'(r1_head_ptr) + int'(r1_head_shift)) % c_HW);
      w_shift_meta = (int'(r1_meta_shift) >= c_MW) ? '0 : (r1_meta << (32'(r1_meta_shift) * 16));
      w_hit        = 1'b0;
      w_hit_id     = '0;
      w_nxt_type   = '0;
      w_nxt_koff   = '0;
      w_nxt_krep   = '0;
      w_nxt_kv     = '0;
      w_nxt_hs     = '0;
      w_nxt_ms     = '0;
      for (int r = 0; r < RULE_NUM; r++) begin
         w_rule_hit[r] = r_valid[r];
         for (int j = 0; j < TYPE_NUM; j++)
            if ((r1_type[8*j +: 8] & r_mask[r][j]) != (r_data[r][j] & r_mask[r][j]))
               w_rule_hit[r] = 1'b0;
      end
      // Descending scan so the lowest-index hit is the last one written.
      for (int r = RULE_NUM - 1; r >= 0; r--)
         if (w_rule_hit[r]) begin
            w_hit    = 1'b1;
            w_hit_id = 4'(r);
         end
      for (int r = 0; r < RULE_NUM; r++)
         if (w_hit && w_hit_id == 4'(r)) begin
            for (int j = 0; j < TYPE_NUM; j++) w_nxt_type[8*j +: 8] = r_type_off[r][j];
            for (int k = 0; k < KEY_NUM; k++) begin
               w_nxt_koff[8*k +: 8] = r_key_off[r][k];
               w_nxt_krep[8*k +: 8] = r_key_rep[r][k];
               w_nxt_kv[k]          = r_key_v[r][k];
            end
            w_nxt_hs = r_head_shift[r];
            w_nxt_ms = r_meta_shift[r];
         end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid       <= 1'b0;
         o_head        <= '0;
         o_meta        <= '0;
         o_head_ptr    <= '0;
         o_type_offset <= '0;
         o_key_offset  <= '0;
         o_key_replace <= '0;
         o_key_v       <= '0;
         o_head_shift  <= '0;
         o_meta_shift  <= '0;
         o_hit         <= 1'b0;
         o_rule_id     <= '0;
      end else begin
         o_valid <= r1_valid;
         if (r1_valid) begin
            o_head        <= w_rot_head;
            o_meta        <= w_shift_meta;
            o_head_ptr    <= w_ptr;
            o_type_offset <= w_nxt_type;
            o_key_offset  <= w_nxt_koff;
            o_key_replace <= w_nxt_krep;
            o_key_v       <= w_nxt_kv;
            o_head_shift  <= w_nxt_hs;
            o_meta_shift  <= w_nxt_ms;
            o_hit         <= w_hit;
            o_rule_id     <= w_hit_id;
         end
      end
   end

   // ---------------- rule table write port --------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         for (int r = 0; r < RULE_NUM; r++) begin
            r_head_shift[r] <= '0;
            r_meta_shift[r] <= '0;
            for (int j = 0; j < TYPE_NUM; j++) begin
               r_data[r][j]     <= '0;
               r_mask[r][j]     <= '0;
               r_type_off[r][j] <= '0;
            end
            for (int k = 0; k < KEY_NUM; k++) begin
               r_key_off[r][k] <= '0;
               r_key_rep[r][k] <= '0;
               r_key_v[r][k]   <= 1'b0;
            end
         end
      end else if (cfg.i_rule_wren && w_layer_ok) begin
         for (int r = 0; r < RULE_NUM; r++)
            if (w_r == 4'(r)) begin
               case (w_sel)
                  3'd0: r_valid[r] <= cfg.i_rule_wdata[0];
                  3'd1: for (int j = 0; j < TYPE_NUM; j++)
                           if (w_idx == 4'(j)) begin
                              r_data[r][j] <= cfg.i_rule_wdata[7:0];
                              r_mask[r][j] <= cfg.i_rule_wdata[15:8];
                           end
                  3'd2: for (int j = 0; j < TYPE_NUM; j++)
                           if (w_idx == 4'(j)) r_type_off[r][j] <= cfg.i_rule_wdata[7:0];
                  3'd3: for (int k = 0; k < KEY_NUM; k++)
                           if (w_idx == 4'(k)) begin
                              r_key_off[r][k] <= cfg.i_rule_wdata[7:0];
                              r_key_rep[r][k] <= cfg.i_rule_wdata[15:8];
                              r_key_v[r][k]   <= cfg.i_rule_wdata[16];
                           end
                  3'd4: r_head_shift[r] <= cfg.i_rule_wdata[7:0];
                  3'd5: r_meta_shift[r] <= cfg.i_rule_wdata[7:0];
                  default: ;
               endcase
            end
      end
   end

`ifdef DEPARSER_LAYER_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic        w_stats_clr;

   assign w_stats_clr = cfg.i_rule_wren && w_layer_ok && (w_sel == 3'd6);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_stats_clr) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (r1_valid) begin
         if (w_hit && r_hit_cnt != '1)    r_hit_cnt  <= r_hit_cnt + 32'd1;
         if (!w_hit && r_miss_cnt != '1)  r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end
`endif

   // ---------------- rule table read port ---------------------------------
   always_comb begin
      w_rdata = '0;
      if (w_layer_ok) begin
         for (int r = 0; r < RULE_NUM; r++)
            if (w_r == 4'(r)) begin
               case (w_sel)
                  3'd0: w_rdata = {31'b0, r_valid[r]};
                  3'd1: for (int j = 0; j < TYPE_NUM; j++)
                           if (w_idx == 4'(j)) w_rdata = {16'b0, r_mask[r][j], r_data[r][j]};
                  3'd2: for (int j = 0; j < TYPE_NUM; j++)
                           if (w_idx == 4'(j)) w_rdata = {24'b0, r_type_off[r][j]};
                  3'd3: for (int k = 0; k < KEY_NUM; k++)
                           if (w_idx == 4'(k))
                              w_rdata = {15'b0, r_key_v[r][k], r_key_rep[r][k], r_key_off[r][k]};
                  3'd4: w_rdata = {24'b0, r_head_shift[r]};
                  3'd5: w_rdata = {24'b0, r_meta_shift[r]};
                  default: ;
               endcase
            end
`ifdef DEPARSER_LAYER_STATS_EN
         if (w_sel == 3'd6) begin
            if (w_idx == 4'd0)      w_rdata = r_hit_cnt;
            else if (w_idx == 4'd1) w_rdata = r_miss_cnt;
         end
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cfg.o_rule_rdata_valid <= 1'b0;
         cfg.o_rule_rdata       <= '0;
      end else begin
         cfg.o_rule_rdata_valid <= cfg.i_rule_rden;
         if (cfg.i_rule_rden) cfg.o_rule_rdata <= w_rdata;
      end
   end
endmodule
`default_nettype wire

// File: doc/deparser_layer_param.md
Name: deparser_layer_param

Overview:
- One generalised deparser layer stage; instances chain to form the deparser pipeline.
- Per packet it does three things:
  - Writes metadata words back into header words, using the current layer's key descriptors.
  - Rotates the header and shifts the metadata by the current layer's shift amounts.
  - Matches the header type bytes against a configurable data/mask rule table. The hit rule supplies the next layer's descriptors.
- Generalises the fixed single-rule layer: widths, key count, type-byte count and rule depth are parameters. Adds a rule-table read-back path, a per-layer config address decode and rotate-with-pointer header handling.

Parameters:
- HEAD_W, 1024, header width in bits; multiple of 16; HW = HEAD_W/16 words.
- META_W, 512, metadata width in bits; multiple of 16; MW = META_W/16 words.
- KEY_NUM, 8, key descriptors per layer; 1..16.
- TYPE_NUM, 2, type bytes per lookup; 1..16.
- RULE_NUM, 4, rule entries; 1..16.
- LAYER_ID, 1, config address match on i_rule_addr[15:12].

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_rule_wren  in  1  config write strobe.
- i_rule_rden  in  1  config read strobe.
- i_rule_addr  in  32  config address.
- i_rule_wdata  in  32  config write data.
- o_rule_rdata_valid  out  1  read data valid.
- o_rule_rdata  out  32  read data.
- i_valid  in  1  packet beat valid.
- i_head  in  HEAD_W  header; word 0 = MSBs; byte 0 = MSB byte.
- i_meta  in  META_W  metadata, same ordering.
- i_head_ptr  in  8  accumulated rotation, in words.
- i_type_offset  in  TYPE_NUM*8  byte offsets of the type bytes in the header.
- i_key_offset  in  KEY_NUM*8  header word index per key.
- i_key_replace  in  KEY_NUM*8  metadata word index per key.
- i_key_v  in  KEY_NUM  key valid bits.
- i_head_shift  in  8  header rotate amount, words.
- i_meta_shift  in  8  metadata shift amount, words.
- o_valid  out  1  output valid.
- o_head  out  HEAD_W  processed header.
- o_meta  out  META_W  processed metadata.
- o_head_ptr  out  8  updated rotation pointer.
- o_type_offset / o_key_offset / o_key_replace / o_key_v / o_head_shift / o_meta_shift  out  as inputs  next-layer descriptors.
- o_hit  out  1  rule hit.
- o_rule_id  out  4  index of the hit rule.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - Rule table cleared: all valid bits 0, all fields 0.
  - Pipeline valid bits cleared; a beat in flight is dropped.
- Pipeline, fixed latency 2 cycles, no backpressure; one beat per cycle sustained.
- Stage 1 (registered), replace:
  - For each k with i_key_v[k]=1, header word i_key_offset[k] is loaded from metadata word i_key_replace[k].
  - If i_key_offset[k] >= HW or i_key_replace[k] >= MW, key k is ignored.
  - If several keys target the same header word, the highest k wins.
- Stage 1, type extraction: type byte j = byte i_type_offset[j] of the replaced header. Offsets >= HEAD_W/8 yield 0x00.
- Stage 2 (registered), shifts:
  - o_head = replaced header rotated left by (i_head_shift mod HW) words; consumed words move to the tail.
  - o_head_ptr = (i_head_ptr + i_head_shift) mod HW.
  - o_meta = metadata shifted left by i_meta_shift words with zero fill; i_meta_shift >= MW gives all zeros.
- Stage 2, lookup:
  - Rule r hits if valid[r]=1 and, for every byte j, (type_j & mask[r][j]) == (data[r][j] & mask[r][j]).
  - The lowest-index hit wins: o_hit=1, o_rule_id=r, and all next-layer descriptors come from rule r.
  - On a miss: o_hit=0, o_rule_id=0, all descriptors 0, including o_key_v=0 and both shifts 0.
- Non-valid beats: o_valid=0; data outputs hold their previous values.
- Config decode:
  - Access is accepted only when i_rule_addr[15:12]==LAYER_ID; otherwise writes are ignored and reads return 0.
  - Field sel = addr[10:8]; r = addr[3:0]; idx = addr[7:4].
  - sel0: valid[r] = wdata[0].
  - sel1: data[r][idx] = wdata[7:0], mask[r][idx] = wdata[15:8].
  - sel2: next type offset[r][idx] = wdata[7:0].
  - sel3: key offset[r][idx] = wdata[7:0], replace offset = wdata[15:8], key valid = wdata[16].
  - sel4: head shift[r] = wdata[7:0].
  - sel5: meta shift[r] = wdata[7:0].
  - r >= RULE_NUM, or idx out of range for the field, means the write is ignored and the read returns 0.
- Config reads: 1-cycle latency; o_rule_rdata_valid pulses 1 cycle after i_rule_rden; read data uses the same bit layout as writes.
- Read and write in the same cycle to the same address: the read returns the old value.
- Write during a lookup: a lookup in the same cycle as a table write uses the pre-write contents; the write is visible from the next cycle.

Optional Feature:
- Macro: DEPARSER_LAYER_STATS_EN.
- When defined:
  - Two 32-bit saturating counters count hits and misses on valid stage-2 beats.
  - Read at sel6: idx0 = hit count, idx1 = miss count.
  - Any write to sel6 clears both counters; reset clears them.
  - Hit/miss counted in the same cycle as a clear: the clear wins.
- When not defined: no counters; sel6 reads 0 and writes to it are ignored.

Test Plan:
- Ethernet replace:
  - Stimulus: keys 0..5 valid, key_offset[k]=k, replace[k]=k; meta words 0..5 = 1111,2222,3333,4444,5555,6666; head_shift=6; head_ptr=0.
  - Required: o_head words HW-6..HW-1 = 1111..6666; o_head_ptr=6; o_valid exactly 2 cycles after i_valid.
- Type match:
  - Stimulus: rule1 data=0x0800, mask=0xFFFF; rule0 data=0x0806, mask=0xFFFF; type_offset={12,13}; head bytes 12..13 = 08 00.
  - Required: o_hit=1, o_rule_id=1, rule1 descriptors on the outputs.
- Priority and miss:
  - Stimulus A: rules 0 and 2 both mask=0x0000.
  - Required A: o_rule_id=0.
  - Stimulus B: all rules invalid.
  - Required B: o_hit=0, o_key_v=0, both shifts 0.
- Boundary:
  - Stimulus: meta_shift=MW; head_shift=HW+2 with head_ptr=HW-1; key_offset=HW.
  - Required: o_meta=0; o_head_ptr=1; key ignored, head unchanged apart from the rotate.
- Config read-back:
  - Stimulus: write sel3 r=2 idx=5 wdata=0x1_0A03, read it back; write with addr[15:12] != LAYER_ID.
  - Required: read returns 0x0001_0A03 one cycle later; the wrong-layer write has no effect.
- Reset with a beat in flight: assert i_rst_n=0 one cycle after i_valid → no o_valid; all rules read back 0.
